// File: rtl/extend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extend_pkg
// Description : Shared types and helpers for the decode-stage immediate extender.
// Revision    : 1.0 - initial release
// ============================================================================
package extend_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IMM_DP8   = 3'b000,
        IMM_MEM12 = 3'b001,
        IMM_BR24  = 3'b010,
        IMM_ROT   = 3'b011,
        IMM_HALF  = 3'b100
    } imm_src_t;

    // Entries are always held at the widest supported width; the top truncates.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] ExtImm;
        logic                 ImmCarry;
        logic                 ImmErr;
    } ext_entry_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
        return (x >> s) | (x << (6'd32 - {1'b0, s}));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate extend / rotate for one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import extend_pkg::*;
(
    input  logic [23:0] instr,
    input  logic [2:0]  immSrc,
    input  logic        carryIn,
    output ext_entry_t  entry
);

    logic [3:0]  w_rot;
    logic [31:0] w_rotVal;

    assign w_rot    = instr[11:8];
    assign w_rotVal = ror32({24'd0, instr[7:0]}, {w_rot, 1'b0});

    always_comb begin
        entry = '0;
        case (immSrc)
            IMM_DP8:   entry.ExtImm = {56'd0, instr[7:0]};
            IMM_MEM12: entry.ExtImm = {52'd0, instr[11:0]};
            IMM_BR24:  entry.ExtImm = {{38{instr[23]}}, instr, 2'b00};
            IMM_ROT: begin
                entry.ExtImm   = {32'd0, w_rotVal};
                // A zero rotate leaves the shifter carry untouched.
                entry.ImmCarry = (w_rot == 4'd0) ? carryIn : w_rotVal[31];
            end
            IMM_HALF:  entry.ExtImm = {56'd0, instr[11:8], instr[3:0]};
            default:   entry.ImmErr = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : extend_pipe
// Description : Immediate extender with a DEPTH-entry valid/ready output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module extend_pipe
    import extend_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [23:0]                Instr,
    input  logic [2:0]                 ImmSrc,
    input  logic                       carry_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           ExtImm,
    output logic                       ImmCarry,
    output logic                       ImmErr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    ext_entry_t              r_mem [DEPTH];
    ext_entry_t              r_last;
    ext_entry_t              w_new;
    ext_entry_t              w_head;
    logic [c_PTR_W-1:0]      r_wrPtr;
    logic [c_PTR_W-1:0]      r_rdPtr;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_live;
    logic                    w_push;
    logic                    w_pop;

    imm_decode u_immDecode (
        .instr   (Instr),
        .immSrc  (ImmSrc),
        .carryIn (carry_in),
        .entry   (w_new)
    );

    // r_live keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_live && (r_count < c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    assign w_head   = out_valid ? r_mem[r_rdPtr] : r_last;
    assign ExtImm   = w_head.ExtImm[WIDTH-1:0];
    assign ImmCarry = w_head.ImmCarry;
    assign ImmErr   = w_head.ImmErr;

    generate
        if (WIDTH < MAX_WIDTH) begin : g_hiBits
            logic w_unusedHi;
            assign w_unusedHi = ^w_head.ExtImm[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_live  <= 1'b0;
            r_last  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
                r_last  <= r_mem[r_rdPtr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
